// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and key-code map for the keypad scanner
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED
    } state_t;

    localparam logic [3:0] ADD_DIV = 4'hA;
    localparam logic [3:0] SUB_MOD = 4'hB;
    localparam logic [3:0] MUL_POW = 4'hC;
    localparam logic [3:0] EQUALS  = 4'hD;
    localparam logic [3:0] NEGATE  = 4'hE;
    localparam logic [3:0] CLEAR   = 4'hF;

    // Indexed by row*4 + column.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2,  4'h3,   ADD_DIV,
        4'h4, 4'h5,  4'h6,   SUB_MOD,
        4'h7, 4'h8,  4'h9,   MUL_POW,
        4'h0, CLEAR, NEGATE, EQUALS
    };

    function automatic logic [3:0] hit_index(input logic [15:0] hits);
        logic [3:0] idx;
        idx = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (hits[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// rtl/keypad_sync.sv - two-flop synchroniser for the column lines
module keypad_sync (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= 4'hF;
            q    <= 4'hF;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad row scan with frame-based debounce
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 25000,
    parameter int DEBOUNCE_FRAMES = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] button,
    output logic       is_pressed
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DONE   = CW'(DEBOUNCE_FRAMES);

    logic [3:0]    col_s;
    logic [DW-1:0] dwell;
    logic [1:0]    row;
    logic [11:0]   hits_acc;
    state_t        state;
    logic [3:0]    cand;
    logic [CW-1:0] cnt;
    logic [CW-1:0] rcnt;

    logic          sample;
    logic          frame_end;
    logic [3:0]    row_hits;
    logic [15:0]   frame_hits;
    logic          hit_none;
    logic          hit_single;
    logic [3:0]    hit_k;

    keypad_sync u_sync (
        .clock (clock),
        .reset (reset),
        .d     (col_n),
        .q     (col_s)
    );

    // Row 3 hits are never stored; they are merged in on the frame-end cycle.
    always_comb begin
        sample     = (dwell == DWELL_LAST);
        frame_end  = sample && (row == 2'd3);
        row_hits   = ~col_s;
        frame_hits = {row_hits, hits_acc};
        hit_none   = (frame_hits == 16'h0000);
        hit_single = !hit_none && ((frame_hits & (frame_hits - 16'd1)) == 16'h0000);
        hit_k      = hit_index(frame_hits);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dwell    <= '0;
            row      <= 2'd0;
            row_n    <= 4'b1110;
            hits_acc <= 12'h000;
        end else if (sample) begin
            dwell <= '0;
            row   <= row + 2'd1;
            row_n <= {row_n[2:0], row_n[3]};
            case (row)
                2'd0:    hits_acc[3:0]  <= row_hits;
                2'd1:    hits_acc[7:4]  <= row_hits;
                2'd2:    hits_acc[11:8] <= row_hits;
                default: hits_acc       <= 12'h000;
            endcase
        end else begin
            dwell <= dwell + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cand       <= 4'h0;
            cnt        <= '0;
            rcnt       <= '0;
            button     <= 4'h0;
            is_pressed <= 1'b0;
        end else if (frame_end) begin
            case (state)
                IDLE: begin
                    if (hit_single) begin
                        cand <= hit_k;
                        cnt  <= CW'(1);
                        if (DEBOUNCE_FRAMES == 1) begin
                            button     <= KEY_MAP[hit_k];
                            is_pressed <= 1'b1;
                            rcnt       <= '0;
                            state      <= PRESSED;
                        end else begin
                            state <= DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (hit_single && hit_k == cand) begin
                        if (cnt + 1'b1 == CNT_DONE) begin
                            button     <= KEY_MAP[cand];
                            is_pressed <= 1'b1;
                            cnt        <= '0;
                            rcnt       <= '0;
                            state      <= PRESSED;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                PRESSED: begin
                    // Any frame still showing the held key keeps it pressed, even alongside others.
                    if (frame_hits[cand]) begin
                        rcnt <= '0;
                    end else if (rcnt + 1'b1 == CNT_DONE) begin
                        is_pressed <= 1'b0;
                        rcnt       <= '0;
                        state      <= IDLE;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
